shift_reg_rr_ctrl: RTL and testbench

Controller that shares one WIDTH-bit load/shift-left register between two requesters and sequences it.
- Round-robin arbitration between the requesters.
- Drives the register's LD and preset_value for one cycle to load the granted word.
- Counts WIDTH shift cycles and presents the register MSB as a qualified serial stream.
- Sits directly in front of the 5-bit left-shifting register (zero fill at LSB) in the ED14 datapath.

---
 rtl/shift_reg_rr_ctrl.sv | 100 ++++++++++
 tb/tb_shift_reg_rr_ctrl.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_rr_ctrl.sv
// Round-robin arbiter and sequencer for one shared WIDTH-bit load/shift-left register.
// Grant pulse and LD appear one cycle after the IDLE decision; bits stream MSB-first from q_msb.
module shift_reg_rr_ctrl #(
  parameter int WIDTH = 5,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  output logic             LD,
  output logic [WIDTH-1:0] preset_value,
  input  logic             q_msb,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             owner,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP_S} state_t;

  state_t           state_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [GW-1:0]    gap_cnt_q;
  logic             last_owner_q;
  logic             owner_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic [WIDTH-1:0] preset_q;
  logic             win_d;

  // On a tie the requester that was not served last wins; otherwise the lone requester.
  assign win_d = (req0 && req1) ? ~last_owner_q : req1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      preset_q     <= '0;
    end else begin
      gnt0_q <= 1'b0;
      gnt1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q      <= LOAD;
            owner_q      <= win_d;
            last_owner_q <= win_d;
            preset_q     <= win_d ? data1 : data0;
            gnt0_q       <= ~win_d;
            gnt1_q       <= win_d;
          end
        end
        LOAD: begin
          state_q   <= SHIFT;
          bit_cnt_q <= '0;
        end
        SHIFT: begin
          if (bit_cnt_q == BIT_LAST) begin
            gap_cnt_q <= '0;
            state_q   <= (GAP > 0) ? GAP_S : IDLE;
          end else begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
          end
        end
        GAP_S: begin
          if (gap_cnt_q == GAP_LAST) state_q <= IDLE;
          else gap_cnt_q <= gap_cnt_q + GW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt0         = gnt0_q;
  assign gnt1         = gnt1_q;
  assign LD           = (state_q == LOAD);
  assign preset_value = preset_q;
  assign ser_valid    = (state_q == SHIFT);
  assign ser_out      = ser_valid & q_msb;
  assign owner        = owner_q;
  assign busy         = (state_q != IDLE);
  assign done         = ser_valid && (bit_cnt_q == BIT_LAST);

endmodule

// File: tb/tb_shift_reg_rr_ctrl.sv
// Bench for shift_reg_rr_ctrl: GAP=1 and GAP=0 instances share stimulus, each drives its own shift register.
module tb_shift_reg_rr_ctrl;
  localparam int W = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] data0 = '0, data1 = '0;

  always #5 clk = ~clk;

  logic gnt0_a, gnt1_a, ld_a, so_a, sv_a, ow_a, bz_a, dn_a;
  logic gnt0_b, gnt1_b, ld_b, so_b, sv_b, ow_b, bz_b, dn_b;
  logic [W-1:0] pv_a, pv_b;
  logic [W-1:0] sr_a = '0, sr_b = '0;

  shift_reg_rr_ctrl #(.WIDTH(W), .GAP(1)) dut_a (
    .clk(clk), .rst(rst), .req0(req0), .data0(data0), .gnt0(gnt0_a),
    .req1(req1), .data1(data1), .gnt1(gnt1_a), .LD(ld_a), .preset_value(pv_a),
    .q_msb(sr_a[W-1]), .ser_out(so_a), .ser_valid(sv_a), .owner(ow_a),
    .busy(bz_a), .done(dn_a)
  );

  shift_reg_rr_ctrl #(.WIDTH(W), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .req0(req0), .data0(data0), .gnt0(gnt0_b),
    .req1(req1), .data1(data1), .gnt1(gnt1_b), .LD(ld_b), .preset_value(pv_b),
    .q_msb(sr_b[W-1]), .ser_out(so_b), .ser_valid(sv_b), .owner(ow_b),
    .busy(bz_b), .done(dn_b)
  );

  // External load/shift-left registers with zero fill.
  always @(posedge clk) begin
    sr_a <= ld_a ? pv_a : (sr_a << 1);
    sr_b <= ld_b ? pv_b : (sr_b << 1);
  end

  typedef struct packed {
    logic g0, g1, ld;
    logic [W-1:0] pv;
    logic sv, so, dn, bz, ow;
  } obs_t;

  obs_t obs_log [0:1][0:2047];
  obs_t exp_log [0:1][0:2047];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  // Reference model: a frame is a timeline relative to the grant cycle g:
  // g = grant+LD, g+1..g+W = bits MSB first, then GAP idle-busy cycles, then a new decision.
  bit           act  [0:1];
  int           gcy  [0:1];
  bit           last [0:1] = '{1'b1, 1'b1};
  logic [W-1:0] pvh  [0:1] = '{'0, '0};
  bit           owh  [0:1];

  always @(negedge clk) begin
    obs_t o [0:1];
    obs_t e;
    bit   w;
    int   gap, k;
    o[0] = {gnt0_a, gnt1_a, ld_a, pv_a, sv_a, so_a, dn_a, bz_a, ow_a};
    o[1] = {gnt0_b, gnt1_b, ld_b, pv_b, sv_b, so_b, dn_b, bz_b, ow_b};
    for (int i = 0; i < 2; i++) begin
      gap = (i == 0) ? 1 : 0;
      e = '0;
      if (!rst) begin
        act[i] = 1'b0; last[i] = 1'b1; pvh[i] = '0; owh[i] = 1'b0;
      end else begin
        if (act[i] && cyc > gcy[i] + W + gap) act[i] = 1'b0;
        e.pv = pvh[i];
        e.ow = owh[i];
        if (!act[i]) begin
          if (req0 || req1) begin
            w = (req0 && req1) ? !last[i] : req1;
            last[i] = w; owh[i] = w; pvh[i] = w ? data1 : data0;
            act[i] = 1'b1; gcy[i] = cyc + 1;
          end
        end else begin
          k = cyc - gcy[i];
          e.bz = 1'b1;
          if (k == 0) begin
            e.ld = 1'b1;
            if (owh[i]) e.g1 = 1'b1; else e.g0 = 1'b1;
          end else if (k <= W) begin
            e.sv = 1'b1;
            e.so = pvh[i][W-k];
            e.dn = (k == W);
          end
        end
      end
      if (cyc < 2048) begin
        obs_log[i][cyc] = o[i];
        exp_log[i][cyc] = e;
      end
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(output int c0);
    tick(1);
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick(2);
    rst = 1'b1;
    c0 = cyc;
  endtask

  task automatic test_reset();
    int c0;
    tick(2);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_log[i][1] !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: got %h expected 0", i, obs_log[i][1]);
      end
    end
    req0 = 1'b1; data0 = 5'b01101;
    tick(3);
    checks++;
    if (obs_log[0][cyc-1] !== '0 || obs_log[1][cyc-1] !== '0) begin
      errors++;
      $display("FAIL reset_ignores_req: got %h/%h expected 0", obs_log[0][cyc-1], obs_log[1][cyc-1]);
    end
    c0 = cyc;
    rst = 1'b1;
    tick(10);
    req0 = 1'b0;
    tick(4);
    checks++;
    if (obs_log[0][c0+1].g0 !== 1'b1 || obs_log[0][c0+1].pv !== 5'b01101) begin
      errors++;
      $display("FAIL reset_first_grant: got g0=%b pv=%b expected g0=1 pv=01101",
               obs_log[0][c0+1].g0, obs_log[0][c0+1].pv);
    end
    for (int c = c0; c < cyc; c++)
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_log[i][c] !== exp_log[i][c]) begin
          errors++;
          $display("FAIL model_reset inst%0d cyc %0d: got %h expected %h", i, c, obs_log[i][c], exp_log[i][c]);
        end
      end
  endtask

  task automatic test_single();
    int c0, g;
    logic [W-1:0] bits, dns;
    do_reset(c0);
    data0 = 5'b10101; req0 = 1'b1;
    tick(3);
    req0 = 1'b0;
    tick(12);
    g = -1;
    for (int c = c0; c < cyc; c++) if (g < 0 && obs_log[0][c].g0) g = c;
    checks++;
    if (g != c0 + 1) begin
      errors++;
      $display("FAIL single_grant_cycle: got %0d expected %0d", g, c0 + 1);
    end else begin
      checks++;
      if (obs_log[0][g].ld !== 1'b1 || obs_log[0][g].pv !== 5'b10101) begin
        errors++;
        $display("FAIL single_load: got ld=%b pv=%b expected ld=1 pv=10101", obs_log[0][g].ld, obs_log[0][g].pv);
      end
      bits = '0; dns = '0;
      for (int k = 1; k <= W; k++) begin
        bits = {bits[W-2:0], obs_log[0][g+k].so & obs_log[0][g+k].sv};
        dns  = {dns[W-2:0], obs_log[0][g+k].dn};
      end
      checks++;
      if (bits !== 5'b10101 || dns !== 5'b00001) begin
        errors++;
        $display("FAIL single_bits: got bits=%b done=%b expected bits=10101 done=00001", bits, dns);
      end
      checks++;
      if (obs_log[0][g+6].bz !== 1'b1 || obs_log[0][g+7].bz !== 1'b0) begin
        errors++;
        $display("FAIL single_busy_fall: got %b%b expected 10", obs_log[0][g+6].bz, obs_log[0][g+7].bz);
      end
    end
    for (int c = c0; c < cyc; c++)
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_log[i][c] !== exp_log[i][c]) begin
          errors++;
          $display("FAIL model_single inst%0d cyc %0d: got %h expected %h", i, c, obs_log[i][c], exp_log[i][c]);
        end
      end
  endtask

  task automatic test_both();
    int c0;
    int gc[$];
    bit gid[$];
    logic [W-1:0] bits, want;
    do_reset(c0);
    data0 = 5'b11111; data1 = 5'b00110; req0 = 1'b1; req1 = 1'b1;
    tick(40);
    req0 = 1'b0; req1 = 1'b0;
    tick(10);
    for (int c = c0; c < cyc; c++)
      if (obs_log[0][c].g0 || obs_log[0][c].g1) begin
        gc.push_back(c);
        gid.push_back(obs_log[0][c].g1);
      end
    checks++;
    if (gc.size() != 5) begin
      errors++;
      $display("FAIL both_grant_count: got %0d expected 5", gc.size());
    end
    for (int k = 0; k < gc.size() && k < 5; k++) begin
      bits = '0;
      for (int j = 1; j <= W; j++) bits = {bits[W-2:0], obs_log[0][gc[k]+j].so};
      want = (k % 2) ? 5'b00110 : 5'b11111;
      checks++;
      if (gc[k] != c0 + 1 + 8 * k || gid[k] != bit'(k % 2) || bits !== want) begin
        errors++;
        $display("FAIL both_grant%0d: got cyc=%0d id=%0d bits=%b expected cyc=%0d id=%0d bits=%b",
                 k, gc[k], gid[k], bits, c0 + 1 + 8 * k, k % 2, want);
      end
    end
    for (int c = c0; c < cyc; c++)
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_log[i][c] !== exp_log[i][c]) begin
          errors++;
          $display("FAIL model_both inst%0d cyc %0d: got %h expected %h", i, c, obs_log[i][c], exp_log[i][c]);
        end
      end
  endtask

  task automatic test_back_to_back();
    int c0, n1, n0, badown;
    do_reset(c0);
    data1 = 5'b10000; req1 = 1'b1;
    tick(30);
    req1 = 1'b0;
    tick(10);
    n1 = 0; n0 = 0; badown = 0;
    for (int c = c0; c < cyc; c++) begin
      if (obs_log[0][c].g0) n0++;
      if (obs_log[0][c].g1) begin
        checks++;
        if (c != c0 + 1 + 8 * n1) begin
          errors++;
          $display("FAIL b2b_spacing: got cyc %0d expected %0d", c, c0 + 1 + 8 * n1);
        end
        n1++;
      end
      if (c > c0 && obs_log[0][c].ow !== 1'b1) badown++;
    end
    checks++;
    if (n1 != 4 || n0 != 0 || badown != 0) begin
      errors++;
      $display("FAIL b2b_summary: got gnt1=%0d gnt0=%0d owner_bad=%0d expected 4 0 0", n1, n0, badown);
    end
    for (int c = c0; c < cyc; c++)
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_log[i][c] !== exp_log[i][c]) begin
          errors++;
          $display("FAIL model_b2b inst%0d cyc %0d: got %h expected %h", i, c, obs_log[i][c], exp_log[i][c]);
        end
      end
  endtask

  task automatic test_reset_mid();
    int c0, rs, ndone;
    do_reset(c0);
    data0 = 5'($urandom); req0 = 1'b1;
    tick(4);
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({gnt0_a, gnt1_a, ld_a, pv_a, sv_a, so_a, dn_a, bz_a, ow_a} !== '0) begin
      errors++;
      $display("FAIL midreset_immediate: got %h expected 0",
               {gnt0_a, gnt1_a, ld_a, pv_a, sv_a, so_a, dn_a, bz_a, ow_a});
    end
    tick(2);
    rst = 1'b1;
    rs = cyc;
    tick(12);
    req0 = 1'b0;
    tick(10);
    ndone = 0;
    for (int c = c0; c < rs; c++) if (obs_log[0][c].dn || obs_log[1][c].dn) ndone++;
    checks++;
    if (obs_log[0][c0+3].sv !== 1'b1 || ndone != 0) begin
      errors++;
      $display("FAIL midreset_drop: got sv=%b dones=%0d expected sv=1 dones=0", obs_log[0][c0+3].sv, ndone);
    end
    checks++;
    if (obs_log[0][rs+1].g0 !== 1'b1 || obs_log[0][rs+6].dn !== 1'b1) begin
      errors++;
      $display("FAIL midreset_restart: got g0=%b done=%b expected 1 1", obs_log[0][rs+1].g0, obs_log[0][rs+6].dn);
    end
    for (int c = c0; c < cyc; c++)
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_log[i][c] !== exp_log[i][c]) begin
          errors++;
          $display("FAIL model_midreset inst%0d cyc %0d: got %h expected %h", i, c, obs_log[i][c], exp_log[i][c]);
        end
      end
  endtask

  task automatic test_withdrawn();
    int c0, n0, n1;
    do_reset(c0);
    data0 = 5'($urandom); data1 = 5'($urandom); req0 = 1'b1;
    tick(2);
    req0 = 1'b0; req1 = 1'b1;
    tick(3);
    req1 = 1'b0;
    tick(15);
    n0 = 0; n1 = 0;
    for (int c = c0; c < cyc; c++) begin
      if (obs_log[0][c].g0) n0++;
      if (obs_log[0][c].g1 || obs_log[1][c].g1) n1++;
    end
    checks++;
    if (n0 != 1 || n1 != 0 || obs_log[0][cyc-1].bz !== 1'b0) begin
      errors++;
      $display("FAIL withdrawn: got gnt0=%0d gnt1=%0d busy=%b expected 1 0 0", n0, n1, obs_log[0][cyc-1].bz);
    end
    for (int c = c0; c < cyc; c++)
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_log[i][c] !== exp_log[i][c]) begin
          errors++;
          $display("FAIL model_withdrawn inst%0d cyc %0d: got %h expected %h", i, c, obs_log[i][c], exp_log[i][c]);
        end
      end
  endtask

  task automatic test_gap0();
    int c0;
    int gc[$];
    logic [W-1:0] d0, d1, bits, want;
    do_reset(c0);
    d0 = 5'($urandom); d1 = 5'($urandom);
    data0 = d0; data1 = d1; req0 = 1'b1; req1 = 1'b1;
    tick(35);
    req0 = 1'b0; req1 = 1'b0;
    tick(10);
    for (int c = c0; c < cyc; c++) if (obs_log[1][c].g0 || obs_log[1][c].g1) gc.push_back(c);
    checks++;
    if (gc.size() != 5) begin
      errors++;
      $display("FAIL gap0_grant_count: got %0d expected 5", gc.size());
    end
    for (int k = 0; k < gc.size() && k < 5; k++) begin
      bits = '0;
      for (int j = 1; j <= W; j++) bits = {bits[W-2:0], obs_log[1][gc[k]+j].so};
      want = (k % 2) ? d1 : d0;
      checks++;
      if (gc[k] != c0 + 1 + 7 * k || obs_log[1][gc[k]].g1 != bit'(k % 2) || bits !== want) begin
        errors++;
        $display("FAIL gap0_frame%0d: got cyc=%0d bits=%b expected cyc=%0d bits=%b",
                 k, gc[k], bits, c0 + 1 + 7 * k, want);
      end
      if (k > 0) begin
        checks++;
        if (obs_log[1][gc[k]-1].bz !== 1'b0 || obs_log[1][gc[k]-2].bz !== 1'b1) begin
          errors++;
          $display("FAIL gap0_idle%0d: got busy %b%b expected 10", k, obs_log[1][gc[k]-2].bz, obs_log[1][gc[k]-1].bz);
        end
      end
    end
    for (int c = c0; c < cyc; c++)
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_log[i][c] !== exp_log[i][c]) begin
          errors++;
          $display("FAIL model_gap0 inst%0d cyc %0d: got %h expected %h", i, c, obs_log[i][c], exp_log[i][c]);
        end
      end
  endtask

  task automatic test_random();
    int c0;
    do_reset(c0);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      if ($urandom_range(0, 2) == 0) data0 = 5'($urandom);
      if ($urandom_range(0, 2) == 0) data1 = 5'($urandom);
      rst = ($urandom_range(0, 79) != 0);
      tick(1);
    end
    rst = 1'b1;
    tick(2);
    for (int c = c0; c < cyc; c++)
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_log[i][c] !== exp_log[i][c]) begin
          errors++;
          $display("FAIL model_random inst%0d cyc %0d: got %h expected %h", i, c, obs_log[i][c], exp_log[i][c]);
        end
      end
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_reset_mid();
    test_withdrawn();
    test_gap0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
